// File: rtl/mem_portb_arbiter_if.sv
// Port-B bundle: CPU and loader request channels plus the shared memory port.
interface mem_portb_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic          CpuReq;
    logic          CpuWe;
    logic [DW-1:0] CpuAddr;
    logic [DW-1:0] CpuWData;
    logic          CpuAck;
    logic [DW-1:0] CpuRData;
    logic          CpuErr;

    logic          LdrReq;
    logic          LdrWe;
    logic [DW-1:0] LdrAddr;
    logic [DW-1:0] LdrWData;
    logic          LdrAck;
    logic [DW-1:0] LdrRData;
    logic          LdrErr;

    logic [DW-1:0] AddressB;
    logic [DW-1:0] WriteData;
    logic          EnableWriteB;
    logic [DW-1:0] ReadDataB;
    logic          Owner;
    logic          Busy;

    // Requester / memory side.
    modport master (
        output CpuReq, CpuWe, CpuAddr, CpuWData,
        output LdrReq, LdrWe, LdrAddr, LdrWData,
        output ReadDataB,
        input  CpuAck, CpuRData, CpuErr,
        input  LdrAck, LdrRData, LdrErr,
        input  AddressB, WriteData, EnableWriteB, Owner, Busy
    );

    // Arbiter side.
    modport slave (
        input  CpuReq, CpuWe, CpuAddr, CpuWData,
        input  LdrReq, LdrWe, LdrAddr, LdrWData,
        input  ReadDataB,
        output CpuAck, CpuRData, CpuErr,
        output LdrAck, LdrRData, LdrErr,
        output AddressB, WriteData, EnableWriteB, Owner, Busy
    );
endinterface

// File: rtl/mem_portb_arbiter.sv
// Round-robin arbiter sharing memory port B between the CPU and the UART loader.
// Each access runs IDLE -> ACCESS -> RESP; misaligned words never write.
module mem_portb_arbiter #(
    parameter int unsigned DW = 32
) (
    input logic                clk,
    input logic                reset,
    mem_portb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          we_q, we_d;
    logic          winner_q, winner_d;
    logic          owner_q, owner_d;
    logic          wen_q, wen_d;
    logic          cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
    logic          ldr_ack_q, ldr_ack_d, ldr_err_q, ldr_err_d;
    logic          busy_q, busy_d;
    logic          grant_ldr;
    logic          aligned;

    assign aligned = (addr_q[1:0] == 2'b00);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        winner_d    = winner_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        wen_d       = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        ldr_err_d   = 1'b0;
        grant_ldr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.CpuReq || bus.LdrReq) begin
                    // On a tie the requester that was not granted last wins.
                    grant_ldr = bus.LdrReq && (!bus.CpuReq || !owner_q);
                    winner_d  = grant_ldr;
                    owner_d   = grant_ldr;
                    addr_d    = grant_ldr ? bus.LdrAddr  : bus.CpuAddr;
                    wdata_d   = grant_ldr ? bus.LdrWData : bus.CpuWData;
                    we_d      = grant_ldr ? bus.LdrWe    : bus.CpuWe;
                    wen_d     = we_d && (addr_d[1:0] == 2'b00);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (winner_q) begin
                    ldr_ack_d = 1'b1;
                    ldr_err_d = !aligned;
                    if (!we_q && aligned) ldr_rdata_d = bus.ReadDataB;
                end else begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = !aligned;
                    if (!we_q && aligned) cpu_rdata_d = bus.ReadDataB;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            winner_q    <= 1'b0;
            owner_q     <= 1'b1;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            wen_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            ldr_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            winner_q    <= winner_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            wen_q       <= wen_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            ldr_ack_q   <= ldr_ack_d;
            ldr_err_q   <= ldr_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.AddressB     = addr_q;
    assign bus.WriteData    = wdata_q;
    assign bus.EnableWriteB = wen_q;
    assign bus.CpuAck       = cpu_ack_q;
    assign bus.CpuErr       = cpu_err_q;
    assign bus.CpuRData     = cpu_rdata_q;
    assign bus.LdrAck       = ldr_ack_q;
    assign bus.LdrErr       = ldr_err_q;
    assign bus.LdrRData     = ldr_rdata_q;
    assign bus.Owner        = owner_q;
    assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Directed and randomized checks of mem_portb_arbiter against a transaction-level model.
module tb_mem_portb_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    mem_portb_arbiter_if #(.DW(32)) bus ();
    mem_portb_arbiter #(.DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Memory behind port B: 64 words aliased on address bits [7:2].
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rd [2];
    logic        owner_m;

    function automatic logic [31:0] fill(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0101_0137);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= fill(i);
        end else if (bus.EnableWriteB) begin
            mem[bus.AddressB[7:2]] <= bus.WriteData;
        end
    end
    assign bus.ReadDataB = mem[bus.AddressB[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.CpuReq = 1'b0;
        bus.LdrReq = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        owner_m = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk1("rst_busy", bus.Busy, 1'b0);
        chk1("rst_owner", bus.Owner, 1'b1);
        chk1("rst_wen", bus.EnableWriteB, 1'b0);
        chk("rst_addr", bus.AddressB, 32'h0);
    endtask

    // One full transaction from an IDLE cycle; caller guarantees the DUT is idle.
    task automatic do_txn(input logic creq, input logic cwe, input logic [31:0] caddr,
                          input logic [31:0] cwd, input logic lreq, input logic lwe,
                          input logic [31:0] laddr, input logic [31:0] lwd);
        logic win, we, al;
        logic [31:0] a, d;
        bus.CpuReq = creq; bus.CpuWe = cwe; bus.CpuAddr = caddr; bus.CpuWData = cwd;
        bus.LdrReq = lreq; bus.LdrWe = lwe; bus.LdrAddr = laddr; bus.LdrWData = lwd;
        if (!creq && !lreq) begin
            @(posedge clk); #1;
            chk1("noreq_busy", bus.Busy, 1'b0);
            chk1("noreq_cack", bus.CpuAck, 1'b0);
            chk1("noreq_lack", bus.LdrAck, 1'b0);
            return;
        end
        win = (creq && lreq) ? !owner_m : lreq;
        a   = win ? laddr : caddr;
        d   = win ? lwd : cwd;
        we  = win ? lwe : cwe;
        al  = (a[1:0] == 2'b00);

        @(posedge clk); #1;
        chk1("acc_busy", bus.Busy, 1'b1);
        chk("acc_addr", bus.AddressB, a);
        chk1("acc_wen", bus.EnableWriteB, we && al);
        if (we && al) chk("acc_wdata", bus.WriteData, d);
        chk1("acc_owner", bus.Owner, win);
        chk1("acc_cack", bus.CpuAck, 1'b0);
        chk1("acc_lack", bus.LdrAck, 1'b0);
        owner_m = win;
        if (we && al) ref_mem[a[7:2]] = d;
        if (!we && al) exp_rd[win] = ref_mem[a[7:2]];
        // The winner's inputs are now don't-care; the latched copy must be used.
        if (win) begin
            bus.LdrAddr = $urandom; bus.LdrWData = $urandom; bus.LdrWe = 1'($urandom);
        end else begin
            bus.CpuAddr = $urandom; bus.CpuWData = $urandom; bus.CpuWe = 1'($urandom);
        end

        @(posedge clk); #1;
        chk1("resp_wen", bus.EnableWriteB, 1'b0);
        chk("resp_addr", bus.AddressB, a);
        chk1("resp_cack", bus.CpuAck, !win);
        chk1("resp_lack", bus.LdrAck, win);
        chk1("resp_cerr", bus.CpuErr, !win && !al);
        chk1("resp_lerr", bus.LdrErr, win && !al);
        chk("resp_crdata", bus.CpuRData, exp_rd[0]);
        chk("resp_lrdata", bus.LdrRData, exp_rd[1]);
        if (win) bus.LdrReq = 1'b0; else bus.CpuReq = 1'b0;

        @(posedge clk); #1;
        chk1("idle_busy", bus.Busy, 1'b0);
        chk1("idle_cack", bus.CpuAck, 1'b0);
        chk1("idle_lack", bus.LdrAck, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, la;
        reset = 1'b1;
        mem_init = 1'b1;
        bus.CpuReq = 1'b0; bus.CpuWe = 1'b0; bus.CpuAddr = '0; bus.CpuWData = '0;
        bus.LdrReq = 1'b0; bus.LdrWe = 1'b0; bus.LdrAddr = '0; bus.LdrWData = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = fill(i);
        @(posedge clk); #1;
        mem_init = 1'b0;
        do_reset();
        chk1("rst_cack", bus.CpuAck, 1'b0);
        chk1("rst_lack", bus.LdrAck, 1'b0);
        chk("rst_crdata", bus.CpuRData, 32'h0);
        chk("rst_wdata", bus.WriteData, 32'h0);

        // CPU write then read-back of word 0x10.
        do_txn(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("cpu_rd_0x10", bus.CpuRData, 32'hDEAD_BEEF);

        // Both requesting continuously from reset: strict alternation.
        do_reset();
        for (int t = 0; t < 4; t++)
            do_txn(1'b1, 1'b0, 32'(t * 8), 32'h0, 1'b1, 1'b0, 32'(t * 8 + 4), 32'h0);

        // Misaligned loader write must leave word 0x20 alone.
        do_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0022, 32'h1234_5678);
        chk("misal_mem_0x20", mem[8], ref_mem[8]);

        // Loader write to an MMIO address passes through unchanged.
        do_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FC60, 32'h0000_0005);
        do_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during ACCESS of a write aborts with no ack.
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 32'h0000_0030; bus.CpuWData = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk1("abort_acc_wen", bus.EnableWriteB, 1'b1);
        reset = 1'b1;
        ref_mem[12] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk1("abort_wen", bus.EnableWriteB, 1'b0);
        chk1("abort_cack", bus.CpuAck, 1'b0);
        chk1("abort_busy", bus.Busy, 1'b0);
        chk1("abort_owner", bus.Owner, 1'b1);
        bus.CpuReq = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        owner_m = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk1("abort_cack2", bus.CpuAck, 1'b0);

        // Randomized traffic: mixed requesters, alignments and MMIO addresses.
        for (int t = 0; t < 60; t++) begin
            ra = $urandom;
            la = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) la[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) ra[31:16] = 16'hFFFF;
            if ($urandom_range(0, 4) == 0) la[31:16] = 16'hFFFF;
            do_txn($urandom_range(0, 3) != 0, 1'($urandom), ra, $urandom,
                   $urandom_range(0, 3) != 0, 1'($urandom), la, $urandom);
        end

        for (int i = 0; i < 64; i++) begin
            checks++;
            assert (mem[i] === ref_mem[i]) else begin
                errors++;
                $error("FAIL mem_final[%0d]: observed %h expected %h", i, mem[i], ref_mem[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_portb_arbiter.md
Name: mem_portb_arbiter

Overview:
- Shares data port B of the unified memory/MMIO block between two requesters: the CPU load/store stage (CPU) and the UART program loader (LDR).
- Sequences each access as a fixed three-phase transaction: arbitrate, drive port, respond.
- Arbitration is round-robin on ties.
- Flags misaligned word addresses without touching memory or MMIO.

Parameters:
- DW, 32, data and address width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- CpuReq  input  1  CPU request; held until CpuAck.
- CpuWe  input  1  CPU write (1) or read (0).
- CpuAddr  input  DW  CPU byte address.
- CpuWData  input  DW  CPU write data.
- CpuAck  output  1  one-cycle completion pulse to CPU.
- CpuRData  output  DW  CPU read data, valid when CpuAck=1.
- CpuErr  output  1  with CpuAck: access was misaligned.
- LdrReq, LdrWe, LdrAddr, LdrWData, LdrAck, LdrRData, LdrErr: same directions, widths and meanings as the CPU signals, for LDR.
- AddressB  output  DW  to memory port B address.
- WriteData  output  DW  to memory port B write data.
- EnableWriteB  output  1  to memory port B write enable.
- ReadDataB  input  DW  from memory port B; valid in the cycle after AddressB is driven.
- Owner  output  1  0 = CPU, 1 = LDR; last granted requester.
- Busy  output  1  high when state is not IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - AddressB, WriteData, CpuRData, LdrRData = 0.
  - EnableWriteB, CpuAck, LdrAck, CpuErr, LdrErr, Busy = 0.
  - Owner = 1, so the CPU wins the first tie.
- Reset in any state aborts the transaction with no ack and deasserts EnableWriteB in the same edge.
- FSM has three states:
  - IDLE:
    - No request: stay in IDLE.
    - Only one requester asserting Req: grant it.
    - Both asserting Req: grant the requester ≠ Owner.
    - On grant: latch the winner's Addr/WData/We into internal regs, set Owner = winner, go to ACCESS.
  - ACCESS (one cycle):
    - AddressB = latched address; WriteData = latched data.
    - EnableWriteB = latched We AND aligned, where aligned = (address[1:0] == 0).
    - Misaligned: EnableWriteB = 0 and AddressB = latched address, so the memory or MMIO side may read but the result is discarded.
    - Next state is RESP.
  - RESP (one cycle):
    - EnableWriteB = 0; AddressB is held.
    - Winner's Ack = 1; winner's Err = ~aligned.
    - Read and aligned: winner's RData = ReadDataB, registered at this edge and held until the next ack to that requester.
    - Write or misaligned: winner's RData is unchanged.
    - Next state is IDLE.
- Latency: Req sampled high in IDLE at edge N gives ACCESS in cycle N+1, Ack high in cycle N+2. Throughput is one transaction per 3 cycles.
- Ack is a single-cycle pulse. The loser's Ack and Err stay 0.
- Req changes during ACCESS or RESP are ignored; the latched copies are used. Req still high when the FSM returns to IDLE (cycle N+3) is a new request.
- Simultaneous continuous requests alternate CPU, LDR, CPU, …; neither requester waits more than one transaction.
- Address decoding is not done here; MMIO (0xFFFF_xxxx) addresses pass through unchanged, and read data comes back the same way.
- At most one EnableWriteB cycle per write transaction; EnableWriteB is never high outside ACCESS.
- Busy = (state != IDLE).

Test Plan:
- Reset, then CpuReq=1, CpuWe=1, CpuAddr=0x0000_0010, CpuWData=0xDEADBEEF → AddressB=0x10 and EnableWriteB=1 for exactly one cycle; CpuAck pulses 2 cycles after the request; CpuErr=0; Owner=0.
- CPU read of 0x10 with the memory model returning 0xDEADBEEF → CpuAck pulses with CpuRData=0xDEADBEEF; EnableWriteB stays 0.
- CpuReq and LdrReq held high together for 4 transactions from reset → grant order CPU, LDR, CPU, LDR; acks at cycles 2, 5, 8, 11.
- LdrReq=1, LdrWe=1, LdrAddr=0x0000_0022 → EnableWriteB never asserted; LdrAck=1 and LdrErr=1; memory word 0x20 unchanged.
- LDR write to 0xFFFF_FC60 with data 0x5 → AddressB=0xFFFF_FC60, EnableWriteB=1 for one cycle; LdrAck pulses; CpuAck stays 0.
- reset asserted in the ACCESS cycle of a write → EnableWriteB low after that edge; no ack; state IDLE; Owner=1.
